// File: rtl/usb_fs_pkg.sv
// Shared definitions for the full-speed USB transmit path: PID codes,
// arbiter state encoding and requester identifiers.
package usb_fs_pkg;

  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IN  = 1'b0,
    REQ_OUT = 1'b1
  } req_idx_e;

endpackage

// File: rtl/usb_fs_rr_arb2.sv
// Two-requester round-robin picker: combinational choice, remembers the
// last winner so a tie always goes to the other side.
module usb_fs_rr_arb2
  import usb_fs_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     req_in_i,
  input  logic     req_out_i,
  input  logic     update_i,
  output req_idx_e pick_o,
  output logic     valid_o
);

  req_idx_e rr_last_q;

  always_comb begin
    valid_o = req_in_i | req_out_i;
    if (req_in_i && req_out_i) begin
      pick_o = (rr_last_q == REQ_IN) ? REQ_OUT : REQ_IN;
    end else if (req_in_i) begin
      pick_o = REQ_IN;
    end else begin
      pick_o = REQ_OUT;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last_q <= REQ_IN;
    end else if (update_i) begin
      rr_last_q <= pick_o;
    end
  end

endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// Shares one full-speed transmitter between the IN and OUT engines:
// grants, holds ownership until packet end, enforces an idle gap, watchdog.
module usb_fs_tx_arbiter
  import usb_fs_pkg::*;
#(
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_tx_req,
  input  logic [3:0] in_tx_pid,
  output logic       in_tx_gnt,
  output logic       in_tx_done,
  input  logic       out_tx_req,
  input  logic [3:0] out_tx_pid,
  output logic       out_tx_gnt,
  output logic       out_tx_done,
  output logic       tx_pkt_start,
  output logic [3:0] tx_pid,
  input  logic       tx_pkt_end,
  output logic       tx_busy,
  output logic       tx_timeout
);

  localparam int GAP_W = $clog2((GAP_CYCLES > 2) ? GAP_CYCLES : 2) + 1;
  localparam int WD_W  = $clog2((TIMEOUT_CYCLES > 2) ? TIMEOUT_CYCLES : 2) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state_q, state_d;
  req_idx_e         owner_q, owner_d;
  logic [3:0]       pid_q, pid_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic start_q, start_d, in_gnt_q, in_gnt_d, out_gnt_q, out_gnt_d;
  logic in_done_q, in_done_d, out_done_q, out_done_d, timeout_q, timeout_d;

  req_idx_e pick;
  logic     pick_valid;
  logic     grant;
  logic     end_ok;
  logic     wd_expire;

  assign grant = (state_q == ARB_IDLE) && pick_valid;

  usb_fs_rr_arb2 u_rr (
    .clk_i     (clk),
    .rst_i     (reset),
    .req_in_i  (in_tx_req),
    .req_out_i (out_tx_req),
    .update_i  (grant),
    .pick_o    (pick),
    .valid_o   (pick_valid)
  );

  // An end strobe coincident with our own start belongs to nothing we sent.
  assign end_ok    = tx_pkt_end && !start_q;
  assign wd_expire = (wd_q == WD_LAST);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    pid_d      = pid_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    start_d    = 1'b0;
    in_gnt_d   = 1'b0;
    out_gnt_d  = 1'b0;
    in_done_d  = 1'b0;
    out_done_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d   = ARB_BUSY;
          owner_d   = pick;
          pid_d     = (pick == REQ_IN) ? in_tx_pid : out_tx_pid;
          start_d   = 1'b1;
          in_gnt_d  = (pick == REQ_IN);
          out_gnt_d = (pick == REQ_OUT);
          wd_d      = '0;
        end
      end
      ARB_BUSY: begin
        if (end_ok || wd_expire) begin
          state_d    = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
          in_done_d  = (owner_q == REQ_IN);
          out_done_d = (owner_q == REQ_OUT);
          timeout_d  = !end_ok;
          wd_d       = '0;
          gap_d      = '0;
        end else begin
          // Expiry always leaves BUSY, so the count never passes WD_LAST.
          wd_d = wd_q + 1'b1;
        end
      end
      ARB_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ARB_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= REQ_IN;
      pid_q      <= 4'h0;
      wd_q       <= '0;
      gap_q      <= '0;
      start_q    <= 1'b0;
      in_gnt_q   <= 1'b0;
      out_gnt_q  <= 1'b0;
      in_done_q  <= 1'b0;
      out_done_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      pid_q      <= pid_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      start_q    <= start_d;
      in_gnt_q   <= in_gnt_d;
      out_gnt_q  <= out_gnt_d;
      in_done_q  <= in_done_d;
      out_done_q <= out_done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_pkt_start = start_q;
  assign in_tx_gnt    = in_gnt_q;
  assign out_tx_gnt   = out_gnt_q;
  assign in_tx_done   = in_done_q;
  assign out_tx_done  = out_done_q;
  assign tx_timeout   = timeout_q;
  assign tx_pid       = pid_q;
  assign tx_busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_usb_fs_tx_arbiter.sv
// Bench for usb_fs_tx_arbiter: a per-cycle vector table for the basic flow,
// then directed sequences for ties, watchdog and asynchronous reset.
module tb_usb_fs_tx_arbiter;
  import usb_fs_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_tx_req, out_tx_req, tx_pkt_end;
  logic [3:0] in_tx_pid, out_tx_pid;
  logic       in_tx_gnt, in_tx_done, out_tx_gnt, out_tx_done;
  logic       tx_pkt_start, tx_busy, tx_timeout;
  logic [3:0] tx_pid;

  usb_fs_tx_arbiter #(.GAP_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_tx_req    (in_tx_req),
    .in_tx_pid    (in_tx_pid),
    .in_tx_gnt    (in_tx_gnt),
    .in_tx_done   (in_tx_done),
    .out_tx_req   (out_tx_req),
    .out_tx_pid   (out_tx_pid),
    .out_tx_gnt   (out_tx_gnt),
    .out_tx_done  (out_tx_done),
    .tx_pkt_start (tx_pkt_start),
    .tx_pid       (tx_pid),
    .tx_pkt_end   (tx_pkt_end),
    .tx_busy      (tx_busy),
    .tx_timeout   (tx_timeout)
  );

  always #5 clk = ~clk;

  // Flag bit positions: {start, in_gnt, in_done, out_gnt, out_done, busy, timeout}
  localparam logic [6:0] S  = 7'h40;
  localparam logic [6:0] IG = 7'h20;
  localparam logic [6:0] ID = 7'h10;
  localparam logic [6:0] OG = 7'h08;
  localparam logic [6:0] OD = 7'h04;
  localparam logic [6:0] B  = 7'h02;
  localparam logic [6:0] T  = 7'h01;

  typedef struct {
    logic       in_req;
    logic [3:0] in_pid;
    logic       out_req;
    logic [3:0] out_pid;
    logic       end_p;
    logic [6:0] flags;
    logic [3:0] pid;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [6:0] obs();
    return {tx_pkt_start, in_tx_gnt, in_tx_done, out_tx_gnt, out_tx_done, tx_busy, tx_timeout};
  endfunction

  function automatic void add(logic ir, logic [3:0] ip, logic orq, logic [3:0] op,
                              logic e, logic [6:0] f, logic [3:0] p);
    vec_t v;
    v.in_req = ir; v.in_pid = ip; v.out_req = orq; v.out_pid = op;
    v.end_p = e; v.flags = f; v.pid = p;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_tx_req = 1'b0; in_tx_pid = 4'h0;
    out_tx_req = 1'b0; out_tx_pid = 4'h0;
    tx_pkt_end = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int early;

    // ---- vector table: single IN, spurious ends, gap enforcement ----
    add(0, 4'h0, 0, 4'h0, 1, 7'h00, 4'h0);           // spurious end in IDLE
    add(1, PID_DATA0, 0, 4'h0, 0, S|IG|B, PID_DATA0); // IN granted
    add(0, 4'h0, 0, 4'h0, 1, B, PID_DATA0);           // end during start: ignored
    add(0, 4'h0, 0, 4'h0, 0, B, PID_DATA0);
    add(0, 4'h0, 0, 4'h0, 1, ID|B, PID_DATA0);        // real end -> done
    add(0, 4'h0, 0, 4'h0, 0, B, PID_DATA0);
    add(0, 4'h0, 0, 4'h0, 1, B, PID_DATA0);           // spurious end in GAP
    for (int i = 0; i < 5; i++) add(0, 4'h0, 1, PID_ACK, 0, B, PID_DATA0);
    add(0, 4'h0, 1, PID_ACK, 0, 7'h00, PID_DATA0);    // first IDLE cycle
    add(0, 4'h0, 1, PID_ACK, 0, S|OG|B, PID_ACK);
    add(0, 4'h0, 0, 4'h0, 0, B, PID_ACK);
    add(0, 4'h0, 0, 4'h0, 1, OD|B, PID_ACK);
    for (int i = 0; i < 7; i++) add(0, 4'h0, 1, PID_NAK, 0, B, PID_ACK);
    add(0, 4'h0, 1, PID_NAK, 0, 7'h00, PID_ACK);
    add(0, 4'h0, 1, PID_NAK, 0, S|OG|B, PID_NAK);
    add(0, 4'h0, 0, 4'h0, 1, B, PID_NAK);
    add(0, 4'h0, 0, 4'h0, 1, OD|B, PID_NAK);

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    check("reset_flags", {25'd0, obs()}, 32'd0);
    check("reset_pid", {28'd0, tx_pid}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      in_tx_req  = tbl[i].in_req;
      in_tx_pid  = tbl[i].in_pid;
      out_tx_req = tbl[i].out_req;
      out_tx_pid = tbl[i].out_pid;
      tx_pkt_end = tbl[i].end_p;
      step();
      $display("vec%0d flags=%b pid=%h", i, obs(), tx_pid);
      check($sformatf("vec%0d_flags", i), {25'd0, obs()}, {25'd0, tbl[i].flags});
      check($sformatf("vec%0d_pid", i), {28'd0, tx_pid}, {28'd0, tbl[i].pid});
    end

    // ---- tie after reset goes to OUT, then IN, then OUT again ----
    do_reset();
    in_tx_req = 1'b1; in_tx_pid = PID_DATA1;
    out_tx_req = 1'b1; out_tx_pid = PID_ACK;
    step();
    $display("tie1 flags=%b pid=%h", obs(), tx_pid);
    check("tie1_flags", {25'd0, obs()}, {25'd0, S|OG|B});
    check("tie1_pid", {28'd0, tx_pid}, {28'd0, PID_ACK});
    out_tx_req = 1'b0;
    step();
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    check("tie1_done", {31'd0, out_tx_done}, 32'd1);
    n = 0;
    while (!in_tx_gnt && n < 20) begin step(); n++; end
    $display("tie1 loser granted after %0d cycles pid=%h", n, tx_pid);
    check("tie1_loser_latency", n, 9);
    check("tie1_loser_pid", {28'd0, tx_pid}, {28'd0, PID_DATA1});
    in_tx_req = 1'b0;
    step();
    tx_pkt_end = 1'b1;
    in_tx_req = 1'b1; out_tx_req = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    n = 0;
    while (!(in_tx_gnt || out_tx_gnt) && n < 20) begin step(); n++; end
    $display("tie2 in_gnt=%b out_gnt=%b pid=%h", in_tx_gnt, out_tx_gnt, tx_pid);
    check("tie2_winner", {30'd0, in_tx_gnt, out_tx_gnt}, 32'd1);
    check("tie2_pid", {28'd0, tx_pid}, {28'd0, PID_ACK});

    // ---- watchdog expiry without end ----
    do_reset();
    in_tx_req = 1'b1; in_tx_pid = PID_DATA0;
    step();
    in_tx_req = 1'b0;
    check("wd_start", {31'd0, tx_pkt_start}, 32'd1);
    early = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16 && (in_tx_done || tx_timeout)) early++;
    end
    $display("wd1 done=%b timeout=%b early=%0d", in_tx_done, tx_timeout, early);
    check("wd1_early", early, 0);
    check("wd1_done_timeout", {30'd0, in_tx_done, tx_timeout}, 32'd3);

    // ---- end on the expiry cycle counts as a normal end ----
    in_tx_req = 1'b1;
    n = 0;
    while (!in_tx_gnt && n < 20) begin step(); n++; end
    check("wd2_grant", {31'd0, in_tx_gnt}, 32'd1);
    in_tx_req = 1'b0;
    early = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (in_tx_done || tx_timeout) early++;
    end
    tx_pkt_end = 1'b1;
    step();
    tx_pkt_end = 1'b0;
    $display("wd2 done=%b timeout=%b early=%0d", in_tx_done, tx_timeout, early);
    check("wd2_early", early, 0);
    check("wd2_done_timeout", {30'd0, in_tx_done, tx_timeout}, 32'd2);

    // ---- asynchronous reset mid-packet ----
    do_reset();
    in_tx_req = 1'b1; in_tx_pid = PID_DATA1;
    step();
    in_tx_req = 1'b0;
    step();
    check("arst_pre_busy", {31'd0, tx_busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    $display("arst flags=%b pid=%h", obs(), tx_pid);
    check("arst_flags", {25'd0, obs()}, 32'd0);
    check("arst_pid", {28'd0, tx_pid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_tx_req = 1'b1; in_tx_pid = PID_DATA0;
    out_tx_req = 1'b1; out_tx_pid = PID_ACK;
    step();
    $display("arst tie flags=%b pid=%h", obs(), tx_pid);
    check("arst_tie_flags", {25'd0, obs()}, {25'd0, S|OG|B});
    check("arst_tie_pid", {28'd0, tx_pid}, {28'd0, PID_ACK});
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_fs_tx_arbiter.md
Name: usb_fs_tx_arbiter

Overview:
- Shares the single full-speed USB transmitter (usb_fs_tx) between the IN and OUT protocol engines.
- Arbitrates between simultaneous transmit requests and latches the winning PID.
- Issues a one-cycle tx_pkt_start, then holds ownership until the transmitter reports packet end.
- Enforces a minimum inter-packet gap and recovers via watchdog if the transmitter never reports completion.

Parameters:
- GAP_CYCLES, 8, idle clk cycles enforced after each packet end before the next grant (0 = none); 2 bit times at 48 MHz.
- TIMEOUT_CYCLES, 4096, maximum clk cycles in BUSY without tx_pkt_end before forced release; must be >= 1.

Ports:
- clk  in  1  system clock (48 MHz)
- reset  in  1  asynchronous, active-high reset
- in_tx_req  in  1  IN engine requests transmission; held until in_tx_gnt
- in_tx_pid  in  4  PID for IN engine packet; valid while in_tx_req
- in_tx_gnt  out  1  one-cycle pulse: IN request accepted, packet started
- in_tx_done  out  1  one-cycle pulse: IN packet finished or timed out
- out_tx_req  in  1  OUT engine requests transmission; held until out_tx_gnt
- out_tx_pid  in  4  PID for OUT engine packet
- out_tx_gnt  out  1  one-cycle pulse: OUT request accepted
- out_tx_done  out  1  one-cycle pulse: OUT packet finished or timed out
- tx_pkt_start  out  1  one-cycle start strobe to usb_fs_tx
- tx_pid  out  4  PID to usb_fs_tx, stable from start through packet end
- tx_pkt_end  in  1  one-cycle pulse from usb_fs_tx at end of packet
- tx_busy  out  1  high in any state other than IDLE
- tx_timeout  out  1  one-cycle pulse coincident with done when the watchdog fired

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0, including tx_pid=4'h0.
  - Gap and watchdog counters cleared.
  - rr_last=IN, so the first tie goes to OUT.
- States: IDLE, BUSY, GAP.
- IDLE, when any req is sampled high at cycle N:
  - Pick a winner. Only one requesting means it wins. Both requesting means the one not equal to rr_last wins.
  - Register owner and PID. tx_pid is sampled from the winner's pid at cycle N.
  - At cycle N+1: tx_pkt_start=1, winner's gnt=1, tx_busy=1, state=BUSY, rr_last=winner. Latency is 1 cycle from req to start.
  - The loser's req remains pending; no gnt is issued to it.
- BUSY:
  - tx_pid is held. Watchdog increments every cycle starting at 0 on the first BUSY cycle.
  - tx_pkt_end in the cycle tx_pkt_start is high is ignored; it can only be accepted from the second BUSY cycle onward.
  - On tx_pkt_end: next cycle, owner's done=1 and state=GAP (or IDLE if GAP_CYCLES=0).
  - On watchdog reaching TIMEOUT_CYCLES-1 with no tx_pkt_end: next cycle, owner's done=1, tx_timeout=1, same transition.
  - tx_pkt_end and watchdog expiry in the same cycle: treated as a normal end, tx_timeout=0.
- GAP:
  - Counts GAP_CYCLES cycles with tx_busy=1. Requests are not granted.
  - Then IDLE. A request present on the first IDLE cycle starts on the following cycle.
- tx_pkt_end outside BUSY: ignored.
- req deasserted before gnt: withdrawn, no error. A PID change while req is high before gnt: the PID sampled at arbitration wins.
- Arithmetic:
  - Counter widths are $clog2(max(param,2))+1; no wrap is possible.
  - The watchdog saturates and is cleared on leaving BUSY.
- gnt, done, tx_pkt_start and tx_timeout are strictly single-cycle pulses. A requester may reassert req the cycle after its done.

Decomposition:
- Shared package usb_fs_pkg:
  - PID constants (PID_ACK=4'b0010, PID_NAK=4'b1010, PID_STALL=4'b1110, PID_DATA0=4'b0011, PID_DATA1=4'b1011).
  - Arbiter state enum {ARB_IDLE, ARB_BUSY, ARB_GAP}.
  - Requester index enum {REQ_IN, REQ_OUT}.
- One natural sub-module: usb_fs_rr_arb2, a two-requester round-robin picker holding rr_last (comb pick plus update-on-grant).
- Counters stay inline.

Test Plan:
- Single IN: in_tx_req=1, pid=DATA0 at cycle 10. Expect tx_pkt_start and in_tx_gnt at 11 with tx_pid=4'b0011. tx_pkt_end at 40 gives in_tx_done at 41; tx_busy falls at 49 (GAP_CYCLES=8).
- Tie after reset: both req at cycle 5 (OUT pid=ACK, IN pid=DATA1). Expect OUT granted at 6 with tx_pid=4'b0010. After its end+gap, IN granted with tx_pid=4'b1011. A second tie goes to the alternate requester.
- Gap enforcement: OUT re-requests the cycle after out_tx_done. Expect no tx_pkt_start for 8 cycles; start on the cycle after GAP exits.
- Watchdog: TIMEOUT_CYCLES=16, grant IN, never pulse tx_pkt_end. Expect in_tx_done and tx_timeout on the same cycle, 16 cycles after start. Also apply tx_pkt_end on the expiry cycle and expect tx_timeout=0.
- Spurious end: tx_pkt_end pulsed in IDLE and in GAP. Expect no state change and no done pulses.
- Reset mid-packet: assert reset asynchronously during BUSY between clock edges. Expect all outputs 0 immediately. After release, both req grant OUT first.
